// File: rtl/serial_sub_ctrl_if.sv
// rtl/serial_sub_ctrl_if.sv - request/result bundle between a requester and serial_sub_ctrl
// The ovf signal exists only when SERIAL_SUB_OVF_EN is defined.
interface serial_sub_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;
`ifdef SERIAL_SUB_OVF_EN
  logic             ovf;

  modport master (output start, a, b, input busy, done, diff, bout, ovf);
  modport slave  (input start, a, b, output busy, done, diff, bout, ovf);
`else
  modport master (output start, a, b, input busy, done, diff, bout);
  modport slave  (input start, a, b, output busy, done, diff, bout);
`endif
endinterface

// File: rtl/serial_sub_ctrl.sv
// rtl/serial_sub_ctrl.sv - bit-serial unsigned subtractor, one bit per clock, LSB first
// Define SERIAL_SUB_OVF_EN to add the registered signed-overflow flag bus.ovf.
module serial_sub_ctrl #(
  parameter int  WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  serial_sub_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-2:0] rr;
  logic [CNT_W-1:0] cnt;
  logic             br;
  logic [WIDTH-1:0] diff_q;
  logic             bout_q;
  logic             busy_q;
  logic             done_q;

  logic             hd;
  logic             hb;
  logic             d_bit;
  logic             bo_bit;
  logic [WIDTH-1:0] rr_next;

  // Full subtract built from two half-subtract stages.
  always_comb begin
    hd      = sa[0] ^ sb[0];
    hb      = ~sa[0] & sb[0];
    d_bit   = hd ^ br;
    bo_bit  = hb | (~hd & br);
    rr_next = {d_bit, rr};
  end

`ifdef SERIAL_SUB_OVF_EN
  logic am;
  logic bm;
  logic ovf_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      sa     <= '0;
      sb     <= '0;
      rr     <= '0;
      cnt    <= '0;
      br     <= 1'b0;
      diff_q <= '0;
      bout_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      am     <= 1'b0;
      bm     <= 1'b0;
      ovf_q  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            sa     <= bus.a;
            sb     <= bus.b;
            br     <= 1'b0;
            cnt    <= '0;
            busy_q <= 1'b1;
            state  <= RUN;
`ifdef SERIAL_SUB_OVF_EN
            am     <= bus.a[WIDTH-1];
            bm     <= bus.b[WIDTH-1];
`endif
          end
        end
        RUN: begin
          rr  <= rr_next[WIDTH-1:1];
          sa  <= sa >> 1;
          sb  <= sb >> 1;
          br  <= bo_bit;
          cnt <= cnt + CNT_W'(1);
          if (cnt == LAST) begin
            diff_q <= rr_next;
            bout_q <= bo_bit;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            state  <= DONE;
`ifdef SERIAL_SUB_OVF_EN
            ovf_q  <= (am ^ bm) & (am ^ d_bit);
`endif
          end
        end
        DONE: begin
          done_q <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          busy_q <= 1'b0;
          done_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.diff = diff_q;
  assign bus.bout = bout_q;
`ifdef SERIAL_SUB_OVF_EN
  assign bus.ovf  = ovf_q;
`endif

endmodule

// File: doc/serial_sub_ctrl.md
Name: serial_sub_ctrl

Overview:
- Bit-serial N-bit unsigned subtractor controller that sequences a 1-bit full-subtract cell, one bit per clock, LSB first.
- The full-subtract cell is built from two half-subtract stages: d = a^b^bin, bo = (~a&b) | (~(a^b)&bin).
- Used where area matters more than latency.
- Start/busy/done handshake toward the requester; operands are captured on start and results are held until the next start.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range 2..32.
- CNT_W, $clog2(WIDTH), bit-counter width; derived, not overridden.

Ports:
- clk    input   1      rising-edge clock
- rst_n  input   1      asynchronous active-low reset
- start  input   1      request pulse; sampled only in IDLE
- a      input   WIDTH  minuend, captured on the accepted start
- b      input   WIDTH  subtrahend, captured on the accepted start
- busy   output  1      high while in RUN
- done   output  1      one-cycle pulse when the result is valid
- diff   output  WIDTH  registered (a-b) mod 2^WIDTH
- bout   output  1      registered final borrow; 1 iff a<b unsigned

Interface (already decided):
- One clock, clk.
- Reset rst_n is asynchronous and active-low.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE; busy=0, done=0, diff=0, bout=0.
  - Internal shift registers, borrow flop and counter are cleared.
- States: IDLE, RUN, DONE. Encoding is free; illegal states recover to IDLE.
- IDLE:
  - start=1 at an edge: latch a into sa and b into sb, clear borrow br=0, set cnt=0, go to RUN.
  - start=0: stay in IDLE.
- RUN (busy=1), at each edge:
  - Compute the cell on sa[0], sb[0], br.
  - Shift the d bit into the MSB of a result shift register rr (right shift).
  - Shift sa and sb right by one.
  - Update br with bo.
  - cnt increments by one.
- RUN exit: the edge at which cnt==WIDTH-1 processes the final bit, then:
  - diff is loaded with the complete result and bout with the final borrow.
  - State goes to DONE.
- RUN duration: exactly WIDTH cycles.
- DONE: done=1 and busy=0 for exactly one cycle, then unconditionally return to IDLE.
- Latency: start accepted at edge 0 -> busy=1 from edge 0 to edge WIDTH; diff/bout update at edge WIDTH; done=1 between edges WIDTH and WIDTH+1.
- Back-to-back throughput: one result per WIDTH+2 cycles.
- start during RUN or DONE is ignored; there is no queueing. The requester must re-assert start once IDLE is reached.
- a and b may change freely after the accepted start edge without affecting the result.
- diff and bout hold their last value through IDLE and through a subsequent RUN. They update only at the final RUN edge.
- rst_n asserted mid-RUN aborts the operation and clears all outputs; no done pulse is produced.
- Edge values:
  - a=b gives diff=0, bout=0.
  - a=0, b=2^WIDTH-1 gives diff=1, bout=1.

Optional Feature:
- Macro: SERIAL_SUB_OVF_EN.
- Defined:
  - Adds output port ovf (1 bit).
  - ovf is registered alongside diff: ovf = (a[MSB]^b[MSB]) & (a[MSB]^diff[MSB]), i.e. signed two's-complement overflow of a-b.
  - The operand MSBs are captured at start for this purpose.
  - ovf resets to 0 and holds like diff.
- Undefined: no ovf port and no extra flops; behaviour is otherwise identical.

Test Plan:
- WIDTH=8, reset, then start with a=8'h5A, b=8'h3C -> busy high 8 cycles; done pulse at edge 8; diff=8'h1E, bout=0.
- a=8'h03, b=8'h05 -> diff=8'hFE, bout=1. With the macro defined, a=8'h80, b=8'h01 -> diff=8'h7F, ovf=1.
- start held high continuously with a=b=8'hFF -> operations repeat every 10 cycles; each gives diff=0, bout=0; start is ignored during RUN and DONE.
- Operands changed to random values on the cycle after the accepted start -> result matches the captured operands.
- rst_n pulsed low at RUN cycle 4 -> busy=0, diff=0, bout=0 immediately; no done pulse; the next start completes normally.
- Random regression of 1000 operand pairs at WIDTH=2, 8 and 32 against a behavioural a-b model -> every diff/bout matches; done pulses exactly once per operation.
